// File: rtl/ybus_receiver_if.sv
// ybus_receiver_if: groups the Y-side four-phase handshake, the downstream
// valid/ready stream and the parity status signals of ybus_receiver.
// slave  = the receiver itself, master = the environment driving it.
interface ybus_receiver_if #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [31:0]     YDATA;
   logic            YPARITY;
   logic            YREQ;
   logic            PARTYSEL;
   logic            YACK;
   logic [31:0]     DOUT;
   logic            DVALID;
   logic            DREADY;
   logic [LW-1:0]   LEVEL;
   logic            PERR;
   logic            PERR_CLR;
   logic [CNTW-1:0] ERRCNT;

   modport slave (
      input  YDATA, YPARITY, YREQ, PARTYSEL, DREADY, PERR_CLR,
      output YACK, DOUT, DVALID, LEVEL, PERR, ERRCNT
   );

   modport master (
      output YDATA, YPARITY, YREQ, PARTYSEL, DREADY, PERR_CLR,
      input  YACK, DOUT, DVALID, LEVEL, PERR, ERRCNT
   );
endinterface

// File: rtl/ybus_receiver.sv
// ybus_receiver: accepts 32-bit words over the YREQ/YACK four-phase
// handshake, checks parity, queues good words in a DEPTH-entry FIFO and
// presents them on a valid/ready stream.
// Optional feature macro: YBUS_RX_PARITY_CHECK_EN. When undefined every
// captured word is queued and PERR/ERRCNT stay at zero.
module ybus_receiver #(
   parameter int DEPTH = 4,
   parameter int CNTW  = 8
) (
   input logic             HCLK,
   input logic             HRESET,
   ybus_receiver_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);
   localparam logic [LW-1:0]   LVL_ONE  = LW'(1);
   localparam logic [LW-1:0]   LVL_ZERO = LW'(0);
   localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
   localparam logic [AW-1:0]   PTR_ZERO = AW'(0);
   localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
   localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
   localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } state_e;

   // True when the word plus its parity bit carries the selected parity sense
   // (odd = 1, even = 0).
   function automatic logic parity_ok(input logic [31:0] data,
                                      input logic        par,
                                      input logic        odd);
      return ((^{data, par}) == odd);
   endfunction

   state_e          state_q, state_d;
   logic            yack_q, yack_d;
   logic            dvalid_q, dvalid_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [31:0]     mem_q [DEPTH];
   logic [31:0]     mem_d [DEPTH];
   logic            perr_q, perr_d;
   logic [CNTW-1:0] errcnt_q, errcnt_d;

   logic pop_s;
   logic full_s;
   logic capture_s;
   logic parity_ok_s;
   logic push_s;
   logic perr_evt_s;

   // Space check: a pop on this edge frees a slot, so full-with-pop still accepts.
   always_comb begin
      pop_s  = dvalid_q & bus.DREADY;
      full_s = (level_q == FULL_LVL) & ~pop_s;
   end

   // Handshake FSM: one capture per request, YACK held until YREQ drops.
   always_comb begin
      state_d   = state_q;
      capture_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.YREQ && !full_s) begin
               state_d   = ST_ACK;
               capture_s = 1'b1;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_ACK: begin
            if (!bus.YREQ) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACK;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      yack_d = (state_d == ST_ACK);
   end

   // Parity classification of the captured word.
   always_comb begin
`ifdef YBUS_RX_PARITY_CHECK_EN
      parity_ok_s = parity_ok(bus.YDATA, bus.YPARITY, bus.PARTYSEL);
`else
      parity_ok_s = 1'b1;
`endif
      push_s     = capture_s & parity_ok_s;
      perr_evt_s = capture_s & ~parity_ok_s;
   end

   // FIFO storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
   always_comb begin
      mem_d = mem_q;
      if (push_s) begin
         mem_d[wr_ptr_q] = bus.YDATA;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      dvalid_d = (level_d != LVL_ZERO);
   end

`ifdef YBUS_RX_PARITY_CHECK_EN
   // Sticky error flag and saturating counter; an error capture beats a clear.
   always_comb begin
      if (perr_evt_s) begin
         perr_d = 1'b1;
         if (bus.PERR_CLR) begin
            errcnt_d = CNT_ONE;
         end else if (errcnt_q != CNT_MAX) begin
            errcnt_d = errcnt_q + CNT_ONE;
         end else begin
            errcnt_d = errcnt_q;
         end
      end else if (bus.PERR_CLR) begin
         perr_d   = 1'b0;
         errcnt_d = CNT_ZERO;
      end else begin
         perr_d   = perr_q;
         errcnt_d = errcnt_q;
      end
   end
`else
   logic parity_unused_s;

   // Parity status tied to zero when the parity check is excluded.
   always_comb begin
      perr_d          = 1'b0;
      errcnt_d        = CNT_ZERO;
      parity_unused_s = ^{bus.YPARITY, bus.PARTYSEL, bus.PERR_CLR, perr_evt_s};
   end
`endif

   // State register with synchronous reset; reset discards FIFO contents too.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= ST_IDLE;
         yack_q   <= 1'b0;
         dvalid_q <= 1'b0;
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         level_q  <= LVL_ZERO;
         perr_q   <= 1'b0;
         errcnt_q <= CNT_ZERO;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0000_0000;
         end
      end else begin
         state_q  <= state_d;
         yack_q   <= yack_d;
         dvalid_q <= dvalid_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         perr_q   <= perr_d;
         errcnt_q <= errcnt_d;
         mem_q    <= mem_d;
      end
   end

   assign bus.YACK   = yack_q;
   assign bus.DVALID = dvalid_q;
   assign bus.DOUT   = mem_q[rd_ptr_q];
   assign bus.LEVEL  = level_q;
   assign bus.PERR   = perr_q;
   assign bus.ERRCNT = errcnt_q;
endmodule

// File: tb/tb_ybus_receiver.sv
// tb_ybus_receiver: directed stimulus with a scoreboard queue. The stimulus
// side pushes every word it expects to come out; a negedge monitor pops and
// compares whenever DVALID & DREADY. Status signals are checked directly.
module tb_ybus_receiver;
   localparam int DEPTH = 4;
   localparam int CNTW  = 8;
`ifdef YBUS_RX_PARITY_CHECK_EN
   localparam bit PCHK = 1'b1;
`else
   localparam bit PCHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ybus_receiver_if #(.DEPTH(DEPTH), .CNTW(CNTW)) yb();

   ybus_receiver #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
      .HCLK    (clk),
      .HRESET  (rst),
      .bus     (yb)
   );

   logic [31:0] exp_q [$];
   int n_cmp = 0;
   int n_mis = 0;
   bit stream_on = 1'b0;
   int lvl_max = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: a transfer happens on the next posedge when both are high.
   always @(negedge clk) begin
      if (!rst && yb.DVALID === 1'b1 && yb.DREADY === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL dout_unexpected: got %h with empty scoreboard", yb.DOUT);
         end else begin
            check("dout_order", yb.DOUT, exp_q.pop_front());
         end
      end
   end

   // Peak occupancy while streaming.
   always @(negedge clk) begin
      if (stream_on && int'(yb.LEVEL) > lvl_max) lvl_max = int'(yb.LEVEL);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic odd_par(input logic [31:0] d);
      return ~(^d);
   endfunction

   // One full handshake; ok is the hand-determined parity verdict.
   task automatic put_word(input logic [31:0] d, input logic p, input bit ok);
      int n;
      yb.YDATA   = d;
      yb.YPARITY = p;
      yb.YREQ    = 1'b1;
      if (ok || !PCHK) exp_q.push_back(d);
      n = 0;
      cyc();
      while (yb.YACK !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      check("yack_rise", yb.YACK, 32'd1);
      yb.YREQ = 1'b0;
      cyc();
      check("yack_fall", yb.YACK, 32'd0);
   endtask

   task automatic drain();
      int n;
      yb.DREADY = 1'b1;
      n = 0;
      while (yb.LEVEL != 0 && n < 50) begin
         cyc();
         n++;
      end
      yb.DREADY = 1'b0;
      check("drain_level", yb.LEVEL, 32'd0);
   endtask

   initial begin
      int n;
      logic [31:0] d;
      yb.YDATA    = 32'h0;
      yb.YPARITY  = 1'b0;
      yb.YREQ     = 1'b0;
      yb.PARTYSEL = 1'b1;
      yb.DREADY   = 1'b0;
      yb.PERR_CLR = 1'b0;
      cyc();
      cyc();
      check("rst_yack", yb.YACK, 32'd0);
      check("rst_dvalid", yb.DVALID, 32'd0);
      check("rst_level", yb.LEVEL, 32'd0);
      check("rst_perr", yb.PERR, 32'd0);
      check("rst_errcnt", yb.ERRCNT, 32'd0);
      check("rst_dout", yb.DOUT, 32'd0);
      rst = 1'b0;
      cyc();

      // Single good word: one 1-bit + parity 0 = odd.
      yb.YDATA = 32'h0000_0001; yb.YPARITY = 1'b0; yb.YREQ = 1'b1;
      exp_q.push_back(32'h0000_0001);
      cyc();
      check("t1_yack", yb.YACK, 32'd1);
      check("t1_dvalid", yb.DVALID, 32'd1);
      check("t1_level", yb.LEVEL, 32'd1);
      check("t1_dout", yb.DOUT, 32'h0000_0001);
      check("t1_perr", yb.PERR, 32'd0);
      yb.YREQ = 1'b0;
      cyc();
      check("t1_yack_fall", yb.YACK, 32'd0);
      drain();

      // Bad word: 0x3 has two 1-bits, parity 0 -> even, odd was selected.
      yb.YDATA = 32'h0000_0003; yb.YPARITY = 1'b0; yb.YREQ = 1'b1;
      if (!PCHK) exp_q.push_back(32'h0000_0003);
      cyc();
      check("t2_yack", yb.YACK, 32'd1);
      check("t2_level", yb.LEVEL, PCHK ? 32'd0 : 32'd1);
      check("t2_perr", yb.PERR, PCHK ? 32'd1 : 32'd0);
      check("t2_errcnt", yb.ERRCNT, PCHK ? 32'd1 : 32'd0);
      yb.YREQ = 1'b0;
      cyc();
      check("t2_yack_fall", yb.YACK, 32'd0);
      yb.PERR_CLR = 1'b1;
      cyc();
      yb.PERR_CLR = 1'b0;
      check("t2_clr_perr", yb.PERR, 32'd0);
      check("t2_clr_errcnt", yb.ERRCNT, 32'd0);
      drain();

      // Fill to DEPTH with no reader, then backpressure a fifth word.
      for (int i = 0; i < 4; i++) begin
         d = 32'hA0 + 32'(i);
         put_word(d, odd_par(d), 1'b1);
      end
      check("t3_full_level", yb.LEVEL, 32'd4);
      yb.YDATA = 32'hA4; yb.YPARITY = odd_par(32'hA4); yb.YREQ = 1'b1;
      exp_q.push_back(32'hA4);
      repeat (6) cyc();
      check("t3_backpressure_yack", yb.YACK, 32'd0);
      check("t3_backpressure_level", yb.LEVEL, 32'd4);
      yb.DREADY = 1'b1;
      cyc();
      yb.DREADY = 1'b0;
      check("t3_popcap_yack", yb.YACK, 32'd1);
      check("t3_popcap_level", yb.LEVEL, 32'd4);
      yb.YREQ = 1'b0;
      cyc();
      drain();

      // Streaming with a ready reader: eight words wrap the pointers twice.
      yb.DREADY = 1'b1;
      lvl_max = 0;
      stream_on = 1'b1;
      for (int i = 0; i < 8; i++) begin
         d = 32'hB0 + 32'(i);
         put_word(d, odd_par(d), 1'b1);
      end
      cyc();
      cyc();
      stream_on = 1'b0;
      check("t4_level_max", lvl_max, 32'd1);
      drain();

      // Reset while in ACK with YREQ held: word is captured once more afterwards.
      yb.YDATA = 32'hC5; yb.YPARITY = odd_par(32'hC5); yb.YREQ = 1'b1;
      exp_q.push_back(32'hC5);
      cyc();
      check("t5_pre_yack", yb.YACK, 32'd1);
      check("t5_pre_level", yb.LEVEL, 32'd1);
      rst = 1'b1;
      cyc();
      check("t5_rst_yack", yb.YACK, 32'd0);
      check("t5_rst_level", yb.LEVEL, 32'd0);
      check("t5_rst_dvalid", yb.DVALID, 32'd0);
      exp_q.delete();
      exp_q.push_back(32'hC5);
      rst = 1'b0;
      cyc();
      check("t5_recap_yack", yb.YACK, 32'd1);
      check("t5_recap_level", yb.LEVEL, 32'd1);
      cyc();
      cyc();
      check("t5_single_capture", yb.LEVEL, 32'd1);
      check("t5_dout", yb.DOUT, 32'hC5);
      yb.YREQ = 1'b0;
      cyc();
      drain();

      // Error counter saturation, then clear coinciding with an error capture.
      yb.DREADY = 1'b1;
      for (int i = 0; i < 260; i++) put_word(32'h3, 1'b0, 1'b0);
      check("t6_errcnt_sat", yb.ERRCNT, PCHK ? 32'd255 : 32'd0);
      check("t6_perr", yb.PERR, PCHK ? 32'd1 : 32'd0);
      yb.YDATA = 32'h3; yb.YPARITY = 1'b0; yb.YREQ = 1'b1; yb.PERR_CLR = 1'b1;
      if (!PCHK) exp_q.push_back(32'h3);
      cyc();
      yb.PERR_CLR = 1'b0;
      check("t6_errwins_cnt", yb.ERRCNT, PCHK ? 32'd1 : 32'd0);
      check("t6_errwins_perr", yb.PERR, PCHK ? 32'd1 : 32'd0);
      yb.YREQ = 1'b0;
      cyc();
      drain();

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         cyc();
         n++;
      end
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
